// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall FSM, data-memory freeze, redirect flush and a
// direct-mapped 2-bit branch history table for the 5-stage pipeline.
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   rs_id/rt_id/uses_rs/rt_id    source operands of the ID instruction
//   memRead_ex, rd_ex            load in EX and its destination
//   pc_if -> predict_taken       fetch-time prediction lookup (combinational)
//   branch_ex/taken_ex/pred_ex/pc_ex/jump_ex   EX-stage resolution
//   dmem_req_mem, dhit           MEM-stage data access handshake
//   freeze, stall_pc, stall_ifid, flush_ifid, flush_idex, mispredict
//                                pipeline control, combinational from inputs+state
module hazard_ctrl #(
   parameter int unsigned REG_W     = 5,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned BHT_DEPTH = 16,
   parameter int unsigned LOAD_LAT  = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic             uses_rs_id,
   input  logic             uses_rt_id,
   input  logic             memRead_ex,
   input  logic [REG_W-1:0] rd_ex,
   input  logic [PC_W-1:0]  pc_if,
   output logic             predict_taken,
   input  logic             branch_ex,
   input  logic             taken_ex,
   input  logic             pred_ex,
   input  logic [PC_W-1:0]  pc_ex,
   input  logic             jump_ex,
   input  logic             dmem_req_mem,
   input  logic             dhit,
   output logic             freeze,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             mispredict
);

   localparam int unsigned IDX_W    = $clog2(BHT_DEPTH);
   localparam logic [1:0]  CNT_INIT = 2'(LOAD_LAT - 1);
   localparam logic [1:0]  BHT_RST  = 2'b01;

   typedef enum logic {IDLE, STALL} state_e;

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [1:0]       bht_q [BHT_DEPTH];
   logic [1:0]       bht_d [BHT_DEPTH];

   logic             mem_wait_c;
   logic             redirect_c;
   logic             luh_c;
   logic [IDX_W-1:0] lkp_idx_c;
   logic [IDX_W-1:0] upd_idx_c;
   logic             unused_pc_c;

   assign lkp_idx_c   = pc_if[IDX_W+1:2];
   assign upd_idx_c   = pc_ex[IDX_W+1:2];
   // PC bits outside the table index play no part in prediction.
   assign unused_pc_c = ^{pc_if[PC_W-1:IDX_W+2], pc_if[1:0],
                          pc_ex[PC_W-1:IDX_W+2], pc_ex[1:0]};

   // Lookup reads the registered table, so a same-cycle update is not seen.
   assign predict_taken = bht_q[lkp_idx_c][1];

   // Hazard classification.
   always_comb begin
      mem_wait_c = dmem_req_mem & ~dhit;
      redirect_c = jump_ex | (branch_ex & (taken_ex ^ pred_ex));
      luh_c      = memRead_ex & (rd_ex != '0) &
                   ((uses_rs_id & (rs_id == rd_ex)) | (uses_rt_id & (rt_id == rd_ex)));
   end

   // Next-state and control outputs: wait > redirect > load-use.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      freeze     = 1'b0;
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      mispredict = 1'b0;
      if (mem_wait_c) begin
         freeze = 1'b1;
      end else if (redirect_c) begin
         // The dependent instruction is squashed, so any pending stall is dropped.
         mispredict = 1'b1;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         state_d    = IDLE;
         cnt_d      = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (luh_c) begin
                  stall_pc   = 1'b1;
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = STALL;
                     cnt_d   = CNT_INIT;
                  end
               end
            end
            STALL: begin
               stall_pc   = 1'b1;
               stall_ifid = 1'b1;
               flush_idex = 1'b1;
               cnt_d      = cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   // Saturating counter update; frozen cycles perform none.
   always_comb begin
      bht_d = bht_q;
      if (branch_ex && !mem_wait_c) begin
         if (taken_ex) begin
            if (bht_q[upd_idx_c] != 2'b11) begin
               bht_d[upd_idx_c] = bht_q[upd_idx_c] + 2'd1;
            end
         end else begin
            if (bht_q[upd_idx_c] != 2'b00) begin
               bht_d[upd_idx_c] = bht_q[upd_idx_c] - 2'd1;
            end
         end
      end
   end

   // State, counter and table registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         for (int i = 0; i < int'(BHT_DEPTH); i++) begin
            bht_q[i] <= BHT_RST;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < int'(BHT_DEPTH); i++) begin
            bht_q[i] <= bht_d[i];
         end
      end
   end

endmodule
